// File: rtl/iir_out_buffer.sv
// rtl/iir_out_buffer.sv - decimating output FIFO behind iir1; optional saturation via IIR_OUT_SAT_EN
module iir_out_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int SAT_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic [2:0]                 decim,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

    logic [PW:0]              wptr;
    logic [PW:0]              rptr;
    logic [2:0]               dcnt;
    logic signed [DATA_W-1:0] mem [DEPTH];
    logic signed [DATA_W-1:0] store_data;

    logic keep;
    logic empty;
    logic full;
    logic pop;
    logic push;

`ifdef IIR_OUT_SAT_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'((1 << (SAT_W-1)) - 1);
    localparam logic signed [DATA_W-1:0] SAT_MIN = -SAT_MAX - DATA_W'(1);

    always_comb begin
        store_data = in_data;
        if (in_data > SAT_MAX)
            store_data = SAT_MAX;
        else if (in_data < SAT_MIN)
            store_data = SAT_MIN;
    end
`else
    assign store_data = in_data;
`endif

    // >= rather than == so lowering decim mid-group keeps the next sample instead of wrapping
    assign keep  = in_valid && (dcnt >= decim);
    assign level = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (level == LVL_FULL);
    assign pop   = !empty && out_ready;
    assign push  = keep && (!full || pop);

    assign out_valid = !empty;
    assign out_data  = mem[rptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            dcnt     <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (keep)
                dcnt <= '0;
            else if (in_valid)
                dcnt <= dcnt + 3'd1;

            if (push) begin
                mem[wptr[PW-1:0]] <= store_data;
                wptr              <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;

            // a drop in the same cycle as a clear keeps the flag set
            if (keep && full && !pop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iir_out_buffer.sv
// tb/tb_iir_out_buffer.sv - directed self-checking bench for iir_out_buffer
module tb_iir_out_buffer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic [2:0]        decim;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic [3:0]        level;
    logic              overflow;
    logic              clr_ovf;

    int checks = 0;
    int errors = 0;

    iir_out_buffer #(.DATA_W(8), .DEPTH(8), .SAT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .decim     (decim),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; decim = '0;
        out_ready = 1'b0; clr_ovf = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", out_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0d exp 0", overflow); end
        checks++; if (out_data !== 8'sd0) begin errors++; $display("FAIL reset_data got %0d exp 0", out_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        logic signed [7:0] vals [3];
        vals[0] = 8'sd10; vals[1] = -8'sd3; vals[2] = 8'sd127;
        decim = 3'd0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== vals[i])
                begin errors++; $display("FAIL pass_data[%0d] got %0d/%0d exp 1/%0d", i, out_valid, out_data, vals[i]); end
            checks++; if (level !== 4'd1) begin errors++; $display("FAIL pass_level[%0d] got %0d exp 1", i, level); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || level !== 4'd0)
            begin errors++; $display("FAIL pass_drain got %0d/%0d exp 0/0", out_valid, level); end
    endtask

    task automatic test_decim();
        logic signed [7:0] exp_v;
        decim = 3'd2; out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL decim_level got %0d exp 3", level); end
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_v = 8'(3 * i);
            checks++; if (out_data !== exp_v) begin errors++; $display("FAIL decim_data[%0d] got %0d exp %0d", i, out_data, exp_v); end
            step();
        end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL decim_empty got %0d exp 0", level); end
        decim = 3'd0; out_ready = 1'b0;
    endtask

    task automatic fill8();
        out_ready = 1'b0; decim = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_overflow();
        fill8();
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level8 got %0d exp 8", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %0d exp 0", overflow); end
        in_valid = 1'b1; in_data = 8'sd9;
        step();
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b1 || level !== 4'd8)
            begin errors++; $display("FAIL ovf_drop got %0d/%0d exp 1/8", overflow, level); end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(i))
                begin errors++; $display("FAIL ovf_pop[%0d] got %0d/%0d exp 1/%0d", i, out_valid, out_data, i); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0d exp 0", out_valid); end
        // popping an empty FIFO must not move anything
        step();
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL empty_pop got %0d exp 0", level); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0d exp 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        fill8();
        in_valid = 1'b1; in_data = 8'sd42; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (level !== 4'd8 || overflow !== 1'b0)
            begin errors++; $display("FAIL fpp_state got %0d/%0d exp 8/0", level, overflow); end
        for (int i = 2; i <= 9; i++) begin
            checks++; if (out_data !== ((i == 9) ? 8'sd42 : 8'(i)))
                begin errors++; $display("FAIL fpp_pop[%0d] got %0d exp %0d", i, out_data, (i == 9) ? 42 : i); end
            step();
        end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL fpp_empty got %0d exp 0", level); end
    endtask

    task automatic test_clr_collision();
        fill8();
        in_valid = 1'b1; in_data = 8'sd9;
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_set got %0d exp 1", overflow); end
        in_data = 8'sd10; clr_ovf = 1'b1;
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_collide got %0d exp 1", overflow); end
        in_valid = 1'b0;
        step();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_alone got %0d exp 0", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL clr_drain got %0d exp 0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; decim = 3'd0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL rmid_pre got %0d exp 3", level); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== 4'd0)
            begin errors++; $display("FAIL rmid_async got %0d/%0d exp 0/0", out_valid, level); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_after got %0d exp 0", out_valid); end
    endtask

`ifdef IIR_OUT_SAT_EN
    task automatic test_sat();
        logic signed [7:0] vin [3];
        logic signed [7:0] vexp [3];
        vin[0] = 8'sd100; vin[1] = -8'sd100; vin[2] = 8'sd5;
        vexp[0] = 8'sd7;  vexp[1] = -8'sd8;  vexp[2] = 8'sd5;
        out_ready = 1'b0; decim = 3'd0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vin[i];
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_data !== vexp[i])
                begin errors++; $display("FAIL sat[%0d] got %0d exp %0d", i, out_data, vexp[i]); end
            step();
        end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_decim();
        test_overflow();
        test_full_push_pop();
        test_clr_collision();
`ifdef IIR_OUT_SAT_EN
        test_sat();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_out_buffer.md
# iir_out_buffer

Downstream stage of the first-order IIR filter (`iir1`). It takes the filter's 8-bit signed output stream and optionally decimates it. Kept samples are stored in a small FIFO and delivered through a valid/ready handshake. This decouples the free-running filter from a consumer that may stall.

## Interface
- `DATA_W`, 8: sample width; matches the `iir1` output width.
- `DEPTH`, 8: FIFO depth in samples; must be a power of two, ≥2.
- `SAT_W`, 4: saturation width; used only when `IIR_OUT_SAT_EN` is defined.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  sample strobe; one filter sample per asserted cycle.
- `in_data`  in  DATA_W  signed filter sample (`y_out`).
- `decim`  in  3  decimation select; ratio = `decim`+1, range 1..8.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head sample.
- `out_data`  out  DATA_W  signed head-of-FIFO sample.
- `level`  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag: a kept sample was dropped because the FIFO was full.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Reset values:
  - `out_valid`=0, `level`=0, `overflow`=0, `out_data`=0.
  - Read/write pointers = 0, decimation counter = 0.
- Decimation:
  - `dcnt` counts `in_valid` cycles.
  - If `in_valid` && `dcnt` ≥ `decim`: the sample is kept and `dcnt`←0.
  - Else if `in_valid`: `dcnt`←`dcnt`+1.
  - The last sample of each group is kept.
  - With `decim`=0, every sample is kept.
  - If `decim` is lowered mid-group, the ≥ compare keeps the next sample; no hang.
- Push: a kept sample is written at `wptr`, and `wptr` advances modulo DEPTH.
- Pop: occurs when `out_valid` && `out_ready`; `rptr` advances modulo DEPTH.
- Full (`level`=DEPTH):
  - A kept sample with no pop in the same cycle is dropped, and `overflow`←1.
  - If a pop occurs in the same cycle, the push is accepted, `level` stays DEPTH, and there is no overflow.
- Empty: `out_ready` is ignored; `level` and `rptr` do not change.
- Push and pop in the same cycle (not full): `level` is unchanged and both pointers advance.
- Overflow clear:
  - `clr_ovf`=1 clears `overflow` on the next edge.
  - If an overflow event occurs in the same cycle, set wins.
- Reset asserted mid-operation: all state clears immediately, buffered samples are lost, and `out_valid` drops asynchronously.
- Pointers use an extra wrap bit, so full and empty are distinguished without a separate counter; `level` = `wptr` − `rptr`.

## Timing
- Push-to-visible latency is 1 cycle. A sample kept at edge t appears on `out_data`/`out_valid` after edge t.
- `out_data` is a read of the storage at `rptr`. It is valid whenever `out_valid`=1 and holds stable until the pop edge.
- A pop at edge t presents the next entry after edge t. Full throughput is one push and one pop per cycle.
- `level` and `overflow` are registered and update on the same edge as the push or pop that changes them.
- No combinational path from `out_ready` to `out_valid`.

## Configuration
- `IIR_OUT_SAT_EN` defined:
  - Each kept sample is saturated to the signed SAT_W range [−2^(SAT_W−1), 2^(SAT_W−1)−1] before storage.
  - The stored value is sign-extended to DATA_W.
  - For SAT_W=4: 100 → 7, −100 → −8, 5 → 5.
- `IIR_OUT_SAT_EN` undefined: samples are stored unchanged and SAT_W is ignored.

## Test plan
- Reset, then `decim`=0, `out_ready`=1, push 10, −3, 127 on consecutive cycles. Required: `out_data` = 10, −3, 127 on consecutive cycles, each 1 cycle after its push; `level` ≤ 1.
- `decim`=2, `in_valid` held high, `in_data`=1..9 incrementing. Required: only 3, 6, 9 are stored.
- `out_ready`=0, `decim`=0, push 9 samples (1..9) with DEPTH=8. Required:
  - `level`=8 after the 8th push.
  - Sample 9 is dropped and `overflow`=1.
  - After releasing `out_ready`, the pops are 1..8.
- FIFO full, then `out_ready`=1 and a push of 42 in the same cycle. Required: `level` stays 8, `overflow` stays 0, and 42 emerges last.
- `overflow`=1, then `clr_ovf`=1 coinciding with another full-drop. Required: `overflow` stays 1; a later `clr_ovf` alone clears it.
- Load 3 samples, assert `rst_n`=0 mid-stream. Required: `out_valid`=0 and `level`=0 immediately.
- With `IIR_OUT_SAT_EN` defined, push 100 and −100. Required: read back 7 and −8.
